// File: rtl/jump_ctrl_if.sv
// Handshake/bus bundle between a caller and the conditional-jump controller.
interface jump_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [2:0]        cond;
  logic              zflag;
  logic              oflag;
  logic              cflag;
  logic              sflag;
  logic              mem_req;
  logic              mem_valid;
  logic [7:0]        mem_data;
  logic              busy;
  logic              done;
  logic              taken;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_out;

  // Caller side: issues requests and supplies operand bytes.
  modport master (
    output start, cond, zflag, oflag, cflag, sflag, mem_valid, mem_data,
    input  mem_req, busy, done, taken, pc_load, pc_out
  );

  // Controller side.
  modport slave (
    input  start, cond, zflag, oflag, cflag, sflag, mem_valid, mem_data,
    output mem_req, busy, done, taken, pc_load, pc_out
  );
endinterface

// File: rtl/jump_ctrl.sv
// Conditional-jump controller: fetches a two-byte target (hi, lo), evaluates
// the condition against flags captured at start, and strobes a PC load.
module jump_ctrl #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  jump_ctrl_if.slave  bus
);

  localparam int unsigned TGT_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_HI = 3'd1,
    FETCH_LO = 3'd2,
    EVAL     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t            state;
  logic [2:0]        cond_q;
  logic              z_q;
  logic              o_q;
  logic              c_q;
  logic              s_q;
  logic [TGT_W-1:0]  target_q;
  logic              mem_req_q;
  logic              busy_q;
  logic              done_q;
  logic              taken_q;
  logic              pc_load_q;
  logic [ADDR_W-1:0] pc_q;
  logic              cond_true_c;

  // Condition decode from the flags captured at start.
  always_comb begin
    cond_true_c = 1'b0;
    case (cond_q)
      3'b000:  cond_true_c = 1'b1;
      3'b001:  cond_true_c = z_q;
      3'b010:  cond_true_c = ~z_q;
      3'b011:  cond_true_c = c_q;
      3'b100:  cond_true_c = ~c_q;
      3'b101:  cond_true_c = s_q;
      3'b110:  cond_true_c = o_q;
      3'b111:  cond_true_c = s_q ^ o_q;
      default: cond_true_c = 1'b0;
    endcase
  end

  // Sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cond_q    <= 3'b000;
      z_q       <= 1'b0;
      o_q       <= 1'b0;
      c_q       <= 1'b0;
      s_q       <= 1'b0;
      target_q  <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      pc_load_q <= 1'b0;
      pc_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= FETCH_HI;
            cond_q    <= bus.cond;
            z_q       <= bus.zflag;
            o_q       <= bus.oflag;
            c_q       <= bus.cflag;
            s_q       <= bus.sflag;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        FETCH_HI: begin
          if (bus.mem_valid) begin
            target_q[15:8] <= bus.mem_data;
            state          <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (bus.mem_valid) begin
            target_q[7:0] <= bus.mem_data;
            mem_req_q     <= 1'b0;
            state         <= EVAL;
          end
        end
        EVAL: begin
          // Bytes are always consumed; only the load strobe depends on the condition.
          taken_q   <= cond_true_c;
          pc_load_q <= cond_true_c;
          pc_q      <= cond_true_c ? ADDR_W'(target_q) : '0;
          done_q    <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done_q    <= 1'b0;
          pc_load_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          pc_load_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req = mem_req_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.taken   = taken_q;
  assign bus.pc_load = pc_load_q;
  assign bus.pc_out  = pc_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed latencies and targets.
module tb_jump_ctrl;
  localparam int unsigned ADDR_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jump_ctrl_if #(.ADDR_W(ADDR_W)) bus();
  jump_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Condition table; flags packed as {z,o,c,s}.
  function automatic logic cond_ok(input logic [2:0] c, input logic [3:0] f);
    logic [7:0] t;
    t = {f[0] ^ f[2], f[2], f[0], ~f[1], f[1], ~f[3], f[3], 1'b1};
    return t[c];
  endfunction

  // Reference model: tracks one transaction (bytes outstanding, then a
  // one-cycle evaluation gap, then a one-cycle completion).
  bit         m_busy = 0, m_req = 0, m_done = 0, m_pcl = 0, m_taken = 0;
  int         m_nb = 0;
  logic [2:0] m_cond = '0;
  logic [3:0] m_fl = '0;
  logic [7:0] m_b0 = '0, m_b1 = '0;
  logic [15:0] m_pc = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_req = 0; m_done = 0; m_pcl = 0; m_taken = 0; m_nb = 0; m_pc = '0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1; m_req = 1; m_nb = 0;
        m_cond = bus.cond;
        m_fl = {bus.zflag, bus.oflag, bus.cflag, bus.sflag};
      end
    end else if (m_req) begin
      if (bus.mem_valid) begin
        if (m_nb == 0) m_b0 = bus.mem_data; else m_b1 = bus.mem_data;
        m_nb++;
        if (m_nb == 2) m_req = 0;
      end
    end else if (!m_done) begin
      m_done = 1;
      m_taken = cond_ok(m_cond, m_fl);
      m_pcl = m_taken;
      m_pc = {m_b0, m_b1};
    end else begin
      m_done = 0; m_pcl = 0; m_busy = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("mem_req", 32'(bus.mem_req), 32'(m_req));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("pc_load", 32'(bus.pc_load), 32'(m_pcl));
      if (m_done) chk("taken", 32'(bus.taken), 32'(m_taken));
      if (m_pcl) chk("pc_out", 32'(bus.pc_out), 32'(m_pc));
    end
  end

  task automatic do_start(input logic [2:0] c, input logic [3:0] f, output int t0);
    bus.start = 1'b1;
    bus.cond = c;
    {bus.zflag, bus.oflag, bus.cflag, bus.sflag} = f;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Present one byte after w wait cycles; noisy mode toggles flags and start.
  task automatic feed(input logic [7:0] d, input int w, input bit noisy);
    for (int i = 0; i <= w; i++) begin
      bus.mem_valid = (i == w);
      bus.mem_data = (i == w) ? d : 8'hEE;
      if (noisy) begin
        {bus.zflag, bus.oflag, bus.cflag, bus.sflag} = ~{bus.zflag, bus.oflag, bus.cflag, bus.sflag};
        bus.start = ~bus.start;
      end
      @(negedge clk);
    end
    bus.mem_valid = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int td, output logic tk, output logic pl, output logic [15:0] pc);
    bit ok;
    ok = 0; td = 0; tk = 1'bx; pl = 1'bx; pc = 'x;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        ok = 1; td = cyc; tk = bus.taken; pl = bus.pc_load; pc = bus.pc_out;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] c, input logic [3:0] f, input logic [7:0] hi,
                        input logic [7:0] lo, input int w, input bit noisy, input bit stay,
                        output int lat, output logic tk, output logic pl, output logic [15:0] pc);
    int t0, td;
    do_start(c, f, t0);
    feed(hi, w, noisy);
    feed(lo, w, noisy);
    wait_done(td, tk, pl, pc);
    lat = td - t0;
    if (!stay) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, t0, td, extra, taken_total;
    logic tk, pl;
    logic [15:0] pc;

    reset = 1'b0;
    bus.start = 1'b0; bus.cond = '0;
    bus.zflag = 1'b0; bus.oflag = 1'b0; bus.cflag = 1'b0; bus.sflag = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_taken", 32'(bus.taken), 32'd0);
    chk("rst_pc_load", 32'(bus.pc_load), 32'd0);
    chk("rst_pc_out", 32'(bus.pc_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Z set, taken, zero wait.
    run_op(3'b001, 4'b1000, 8'h12, 8'h34, 0, 0, 0, lat, tk, pl, pc);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_taken", 32'(tk), 32'd1);
    chk("t1_pc_load", 32'(pl), 32'd1);
    chk("t1_pc_out", 32'(pc), 32'h1234);

    // Z clear, not taken, bytes still consumed.
    run_op(3'b001, 4'b0000, 8'hAB, 8'hCD, 0, 0, 0, lat, tk, pl, pc);
    chk("t2_latency", 32'(lat), 32'd4);
    chk("t2_taken", 32'(tk), 32'd0);
    chk("t2_pc_load", 32'(pl), 32'd0);

    // Signed less-than with 3 wait cycles per byte.
    run_op(3'b111, 4'b0001, 8'h40, 8'h02, 3, 0, 0, lat, tk, pl, pc);
    chk("t3_latency", 32'(lat), 32'd10);
    chk("t3_taken", 32'(tk), 32'd1);
    chk("t3_pc_out", 32'(pc), 32'h4002);

    // Flags toggled and start pulsed while busy; captured flags rule.
    run_op(3'b001, 4'b1000, 8'hBE, 8'hEF, 1, 1, 0, lat, tk, pl, pc);
    chk("t4_latency", 32'(lat), 32'd6);
    chk("t4_taken", 32'(tk), 32'd1);
    chk("t4_pc_out", 32'(pc), 32'hBEEF);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) extra++;
      @(negedge clk);
    end
    chk("t4_no_second_done", 32'(extra), 32'd0);

    // Back-to-back: start in DONE cycle ignored, next cycle accepted.
    run_op(3'b010, 4'b0000, 8'h56, 8'h78, 0, 0, 1, lat, tk, pl, pc);
    chk("t5a_pc_out", 32'(pc), 32'h5678);
    bus.start = 1'b1; bus.cond = 3'b001;
    {bus.zflag, bus.oflag, bus.cflag, bus.sflag} = 4'b0000;
    @(negedge clk);
    do_start(3'b000, 4'b0000, t0);
    feed(8'h9A, 0, 0);
    feed(8'hBC, 0, 0);
    wait_done(td, tk, pl, pc);
    chk("t5b_latency", 32'(td - t0), 32'd4);
    chk("t5b_taken", 32'(tk), 32'd1);
    chk("t5b_pc_out", 32'(pc), 32'h9ABC);
    @(negedge clk);

    // Reset during FETCH_LO aborts the operation asynchronously.
    do_start(3'b000, 4'b0000, t0);
    feed(8'h99, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t6_done", 32'(bus.done), 32'd0);
    chk("t6_taken", 32'(bus.taken), 32'd0);
    chk("t6_pc_load", 32'(bus.pc_load), 32'd0);
    chk("t6_pc_out", 32'(bus.pc_out), 32'd0);
    @(negedge clk);
    bus.start = 1'b1; bus.mem_valid = 1'b1; bus.mem_data = 8'h77;
    repeat (2) begin
      @(negedge clk);
      chk("t6_held_busy", 32'(bus.busy), 32'd0);
      chk("t6_held_done", 32'(bus.done), 32'd0);
    end
    bus.start = 1'b0; bus.mem_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    run_op(3'b000, 4'b0000, 8'h00, 8'h01, 0, 0, 0, lat, tk, pl, pc);
    chk("t6_latency", 32'(lat), 32'd4);
    chk("t6_taken_after", 32'(tk), 32'd1);
    chk("t6_pc_out_after", 32'(pc), 32'h0001);

    // Sweep of all conditions against all flag combinations.
    taken_total = 0;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 16; f++) begin
        run_op(3'(c), 4'(f), 8'(c), 8'(f), 0, 0, 0, lat, tk, pl, pc);
        chk("sweep_latency", 32'(lat), 32'd4);
        if (tk === 1'b1) taken_total++;
      end
    end
    chk("sweep_taken_total", 32'(taken_total), 32'd72);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
